// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP32 constants, exception bit positions and accumulator state type
package fp_pkg;
    localparam int FP32_W = 32;
    localparam int EXC_W  = 5;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // exception vector bit positions: invalid, div-by-zero, overflow, underflow, inexact
    localparam int EXC_NV = 4;
    localparam int EXC_DZ = 3;
    localparam int EXC_OF = 2;
    localparam int EXC_UF = 1;
    localparam int EXC_NX = 0;

    localparam logic [FP32_W-1:0] FP32_POS_ZERO = 32'h0000_0000;
    localparam logic [FP32_W-1:0] FP32_POS_INF  = 32'h7f80_0000;
    localparam logic [FP32_W-1:0] FP32_QNAN     = 32'h7fc0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;
endpackage

// File: rtl/add_sub.sv
// rtl/add_sub.sv - combinational FP32 adder/subtractor with IEEE rounding modes and exception flags
module add_sub
    import fp_pkg::*;
(
    input  logic [FP32_W-1:0] in_x,
    input  logic [FP32_W-1:0] in_y,
    input  logic              operation,
    input  logic [2:0]        round_mode,
    output logic [FP32_W-1:0] out_z,
    output logic [EXC_W-1:0]  exceptions
);
    logic        sy_eff, sa, sb, eff_sub, swap;
    logic        x_nan, y_nan, x_inf, y_inf;
    logic [7:0]  ea_f, eb_f;
    logic [22:0] fa, fb;
    logic [8:0]  ea, eb, d;
    logic [26:0] a_ext, b_ext, b_sh, n;
    logic [27:0] sum;
    logic [4:0]  lz, sh;
    logic [9:0]  e_r, e_f;
    logic        lsb, rb, st, inexact, up, to_max;
    logic [24:0] mant_r;

    always_comb begin
        b_sh       = '0;
        n          = '0;
        e_r        = '0;
        sh         = '0;
        up         = 1'b0;
        exceptions = '0;

        sy_eff = in_y[31] ^ operation;
        x_nan  = (in_x[30:23] == 8'hff) && (in_x[22:0] != 23'd0);
        y_nan  = (in_y[30:23] == 8'hff) && (in_y[22:0] != 23'd0);
        x_inf  = (in_x[30:23] == 8'hff) && (in_x[22:0] == 23'd0);
        y_inf  = (in_y[30:23] == 8'hff) && (in_y[22:0] == 23'd0);

        // operand a always has the larger magnitude, so the difference never goes negative
        swap = in_y[30:0] > in_x[30:0];
        {sa, ea_f, fa} = swap ? {sy_eff, in_y[30:0]} : in_x;
        {sb, eb_f, fb} = swap ? in_x : {sy_eff, in_y[30:0]};
        eff_sub = sa ^ sb;

        ea    = (ea_f == 8'd0) ? 9'd1 : {1'b0, ea_f};
        eb    = (eb_f == 8'd0) ? 9'd1 : {1'b0, eb_f};
        a_ext = {(ea_f != 8'd0), fa, 3'b000};
        b_ext = {(eb_f != 8'd0), fb, 3'b000};
        d     = ea - eb;

        if (d >= 9'd27)
            b_sh = {26'd0, |b_ext};
        else
            b_sh = (b_ext >> d) | {26'd0, |(b_ext & ((27'd1 << d) - 27'd1))};

        sum = eff_sub ? ({1'b0, a_ext} - {1'b0, b_sh}) : ({1'b0, a_ext} + {1'b0, b_sh});

        lz = 5'd27;
        for (int i = 0; i < 27; i++)
            if (sum[i]) lz = 5'(26 - i);

        // left shift is capped so results below the normal range come out subnormal
        if (sum[27]) begin
            n   = {sum[27:2], |sum[1:0]};
            e_r = {1'b0, ea} + 10'd1;
        end else begin
            sh  = ({4'd0, lz} < ea) ? lz : 5'(ea - 9'd1);
            n   = sum[26:0] << sh;
            e_r = {1'b0, ea} - {5'd0, sh};
        end

        lsb     = n[3];
        rb      = n[2];
        st      = |n[1:0];
        inexact = |n[2:0];
        case (round_mode)
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = inexact & sa;
            RM_RUP:  up = inexact & ~sa;
            RM_RMM:  up = rb;
            default: up = rb & (st | lsb);
        endcase

        mant_r = {1'b0, n[26:3]} + {24'd0, up};
        e_f    = mant_r[24] ? (e_r + 10'd1) : (mant_r[23] ? e_r : 10'd0);
        to_max = (round_mode == RM_RTZ) || ((round_mode == RM_RDN) && !sa) ||
                 ((round_mode == RM_RUP) && sa);

        out_z = {sa, e_f[7:0], mant_r[22:0]};
        if (x_nan || y_nan || (x_inf && y_inf && (in_x[31] != sy_eff))) begin
            out_z              = FP32_QNAN;
            exceptions[EXC_NV] = 1'b1;
        end else if (x_inf) begin
            out_z = in_x;
        end else if (y_inf) begin
            out_z = {sy_eff, in_y[30:0]};
        end else if (sum == 28'd0) begin
            out_z = FP32_POS_ZERO | {(eff_sub ? (round_mode == RM_RDN) : sa), 31'd0};
        end else if (e_f >= 10'd255) begin
            exceptions[EXC_OF] = 1'b1;
            exceptions[EXC_NX] = 1'b1;
            out_z = to_max ? {sa, 31'h7f7f_ffff} : {sa, FP32_POS_INF[30:0]};
        end else begin
            exceptions[EXC_NX] = inexact;
            exceptions[EXC_UF] = inexact & ~n[26];
        end
        exceptions[EXC_DZ] = 1'b0;
    end
endmodule

// File: rtl/fp32_accumulator.sv
// rtl/fp32_accumulator.sv - streaming FP32 reduction: folds each accepted operand into a running sum
module fp32_accumulator
    import fp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP32_W-1:0] in_data,
    input  logic              in_sub,
    input  logic              in_last,
    input  logic [2:0]        round_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP32_W-1:0] out_z,
    output logic [EXC_W-1:0]  out_exceptions,
    output logic [CNT_W-1:0]  out_count
);
    acc_state_t        state;
    logic [FP32_W-1:0] acc, acc_next, add_z, res_z;
    logic [EXC_W-1:0]  exc, exc_next, add_exc, res_exc;
    logic [CNT_W-1:0]  count, count_next, res_count;
    logic [2:0]        rm_q;
    logic              accept;

    add_sub u_add_sub (
        .in_x       (acc),
        .in_y       (in_data),
        .operation  (in_sub),
        .round_mode (rm_q),
        .out_z      (add_z),
        .exceptions (add_exc)
    );

    assign in_ready       = (state != DONE);
    assign out_valid      = (state == DONE);
    assign accept         = in_valid && in_ready;
    assign out_z          = res_z;
    assign out_exceptions = res_exc;
    assign out_count      = res_count;

    // first beat bypasses the adder so a lone element is passed through exactly
    always_comb begin
        acc_next   = add_z;
        exc_next   = exc | add_exc;
        count_next = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
        if (state == IDLE) begin
            acc_next   = {in_data[31] ^ in_sub, in_data[30:0]};
            exc_next   = '0;
            count_next = CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= FP32_POS_ZERO;
            exc       <= '0;
            count     <= '0;
            rm_q      <= RM_RNE;
            res_z     <= FP32_POS_ZERO;
            res_exc   <= '0;
            res_count <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc   <= acc_next;
                        exc   <= exc_next;
                        count <= count_next;
                        if (state == IDLE)
                            rm_q <= round_mode;
                        if (in_last) begin
                            state     <= DONE;
                            res_z     <= acc_next;
                            res_exc   <= exc_next;
                            res_count <= count_next;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_accumulator.sv
// tb/tb_fp32_accumulator.sv - directed self-checking bench for fp32_accumulator
module tb_fp32_accumulator;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_sub, in_last;
    logic [31:0]      in_data;
    logic [2:0]       round_mode;
    logic             out_valid, out_ready;
    logic [31:0]      out_z;
    logic [4:0]       out_exceptions;
    logic [CNT_W-1:0] out_count;
    int               n_tests = 0;
    int               n_fail = 0;

    fp32_accumulator #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_sub         (in_sub),
        .in_last        (in_last),
        .round_mode     (round_mode),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_z          (out_z),
        .out_exceptions (out_exceptions),
        .out_count      (out_count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] d, input logic s, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = s;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_sub   = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_sub = 1'b0; in_last = 1'b0;
        round_mode = 3'b000; out_ready = 1'b0;
        #2;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_tests++; if (out_z !== 32'h0) begin n_fail++; $display("FAIL reset_out_z: got %h expected 00000000", out_z); end
        n_tests++; if (out_exceptions !== 5'd0) begin n_fail++; $display("FAIL reset_exc: got %b expected 00000", out_exceptions); end
        n_tests++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", out_count); end
        #10 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_simple_sum();
        drive(32'h3f800000, 1'b0, 1'b0);
        drive(32'h3f800000, 1'b0, 1'b0);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL simple_early_valid: got %b expected 0", out_valid); end
        drive(32'h3f800000, 1'b0, 1'b1);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL simple_valid: got %b expected 1", out_valid); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL simple_in_ready: got %b expected 0", in_ready); end
        n_tests++; if (out_z !== 32'h40400000) begin n_fail++; $display("FAIL simple_z: got %h expected 40400000", out_z); end
        n_tests++; if (out_count !== 3'd3) begin n_fail++; $display("FAIL simple_count: got %0d expected 3", out_count); end
        n_tests++; if (out_exceptions !== 5'd0) begin n_fail++; $display("FAIL simple_exc: got %b expected 00000", out_exceptions); end
        consume();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL simple_valid_drop: got %b expected 0", out_valid); end
        n_tests++; if (out_z !== 32'h40400000) begin n_fail++; $display("FAIL simple_z_hold: got %h expected 40400000", out_z); end
    endtask

    task automatic test_subtract();
        drive(32'h40000000, 1'b0, 1'b0);
        drive(32'h3f800000, 1'b1, 1'b1);
        n_tests++; if (out_z !== 32'h3f800000) begin n_fail++; $display("FAIL sub_z: got %h expected 3f800000", out_z); end
        n_tests++; if (out_count !== 3'd2) begin n_fail++; $display("FAIL sub_count: got %0d expected 2", out_count); end
        consume();
        drive(32'h3f800000, 1'b1, 1'b1);
        n_tests++; if (out_z !== 32'hbf800000) begin n_fail++; $display("FAIL single_z: got %h expected bf800000", out_z); end
        n_tests++; if (out_count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", out_count); end
        consume();
    endtask

    task automatic test_special();
        drive(32'h7f800000, 1'b0, 1'b0);
        drive(32'h3f800000, 1'b0, 1'b1);
        n_tests++; if (out_z !== 32'h7f800000) begin n_fail++; $display("FAIL inf_z: got %h expected 7f800000", out_z); end
        n_tests++; if (out_exceptions !== 5'd0) begin n_fail++; $display("FAIL inf_exc: got %b expected 00000", out_exceptions); end
        consume();
        drive(32'h7fc00000, 1'b0, 1'b0);
        drive(32'h3f800000, 1'b0, 1'b1);
        n_tests++; if (out_z !== 32'h7fc00000) begin n_fail++; $display("FAIL nan_z: got %h expected 7fc00000", out_z); end
        n_tests++; if (out_exceptions !== 5'b10000) begin n_fail++; $display("FAIL nan_exc: got %b expected 10000", out_exceptions); end
        consume();
    endtask

    task automatic test_overflow();
        drive(32'h7f7fffff, 1'b0, 1'b0);
        drive(32'h7f7fffff, 1'b0, 1'b1);
        n_tests++; if (out_z !== 32'h7f800000) begin n_fail++; $display("FAIL ovf_z: got %h expected 7f800000", out_z); end
        n_tests++; if (out_exceptions !== 5'b00101) begin n_fail++; $display("FAIL ovf_exc: got %b expected 00101", out_exceptions); end
        consume();
        drive(32'h3f800000, 1'b0, 1'b1);
        n_tests++; if (out_exceptions !== 5'd0) begin n_fail++; $display("FAIL sticky_clear: got %b expected 00000", out_exceptions); end
        n_tests++; if (out_z !== 32'h3f800000) begin n_fail++; $display("FAIL after_ovf_z: got %h expected 3f800000", out_z); end
        consume();
    endtask

    task automatic test_round_mode();
        round_mode = 3'b011;
        drive(32'h3f800000, 1'b0, 1'b0);
        round_mode = 3'b000;
        drive(32'h33800000, 1'b0, 1'b1);
        n_tests++; if (out_z !== 32'h3f800001) begin n_fail++; $display("FAIL rup_z: got %h expected 3f800001", out_z); end
        n_tests++; if (out_exceptions !== 5'b00001) begin n_fail++; $display("FAIL rup_exc: got %b expected 00001", out_exceptions); end
        consume();
        drive(32'h3f800000, 1'b0, 1'b0);
        drive(32'h33800000, 1'b0, 1'b1);
        n_tests++; if (out_z !== 32'h3f800000) begin n_fail++; $display("FAIL rne_tie_z: got %h expected 3f800000", out_z); end
        consume();
    endtask

    task automatic test_backpressure();
        drive(32'h3f800000, 1'b0, 1'b0);
        drive(32'h40000000, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, out_valid); end
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready); end
            n_tests++; if (out_z !== 32'h40400000) begin n_fail++; $display("FAIL bp_z[%0d]: got %h expected 40400000", c, out_z); end
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h40a00000; in_sub = 1'b0; in_last = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_bubble_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_z !== 32'h40400000) begin n_fail++; $display("FAIL bp_bubble_z: got %h expected 40400000", out_z); end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        n_tests++; if (out_z !== 32'h40a00000) begin n_fail++; $display("FAIL bp_next_z: got %h expected 40a00000", out_z); end
        n_tests++; if (out_count !== 3'd1) begin n_fail++; $display("FAIL bp_next_count: got %0d expected 1", out_count); end
        consume();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 9; i++)
            drive(32'h3f800000, 1'b0, i == 8);
        n_tests++; if (out_count !== 3'd7) begin n_fail++; $display("FAIL sat_count: got %0d expected 7", out_count); end
        n_tests++; if (out_z !== 32'h41100000) begin n_fail++; $display("FAIL sat_z: got %h expected 41100000", out_z); end
        consume();
    endtask

    task automatic test_reset_mid();
        drive(32'h3f800000, 1'b0, 1'b0);
        drive(32'h3f800000, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_tests++; if (out_z !== 32'h0) begin n_fail++; $display("FAIL rstmid_z: got %h expected 00000000", out_z); end
        n_tests++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 0", out_count); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(32'h40000000, 1'b0, 1'b1);
        n_tests++; if (out_z !== 32'h40000000) begin n_fail++; $display("FAIL rstmid_new_z: got %h expected 40000000", out_z); end
        n_tests++; if (out_count !== 3'd1) begin n_fail++; $display("FAIL rstmid_new_count: got %0d expected 1", out_count); end
        consume();
    endtask

    initial begin
        test_reset();
        test_simple_sum();
        test_subtract();
        test_special();
        test_overflow();
        test_round_mode();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fp32_accumulator.md
# fp32_accumulator

Sequential FP32 reduction stage that sits directly upstream of the `add_sub` unit and drives it. It accepts a stream of FP32 operands, typically products from the multiplier stage, one per cycle over a valid/ready handshake. It folds each operand into a running sum through a single combinational `add_sub` instance and presents the final sum with sticky exceptions once the vector's last element is accepted. It is the accumulate half of a neuron's dot-product datapath.

## Interface
- `CNT_W`, default 16: width of the element counter and `out_count`.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous reset, active-high.
- `in_valid`, input, 1: `in_data`, `in_sub` and `in_last` are valid.
- `in_ready`, output, 1: the block can accept an element this cycle.
- `in_data`, input, 32: FP32 operand.
- `in_sub`, input, 1: 1 means subtract this operand (drives the `add_sub` `operation` input); 0 means add.
- `in_last`, input, 1: this element ends the vector.
- `round_mode`, input, 3: `add_sub` rounding mode; sampled on the first beat of each vector.
- `out_valid`, output, 1: the result is held and valid.
- `out_ready`, input, 1: downstream accepts the result.
- `out_z`, output, 32: accumulated FP32 sum.
- `out_exceptions`, output, 5: bitwise OR of every `add_sub` `exceptions` vector produced during the vector, in the same bit order.
- `out_count`, output, `CNT_W`: number of elements accepted in the vector; saturates at all-ones.

## Operation
- FSM states: `IDLE`, `ACCUM`, `DONE`.
- An element is accepted when `in_valid` and `in_ready` are both 1 on a clock edge.
- `IDLE`, first accepted beat:
  - `acc` is loaded with `in_data` directly, with the sign bit inverted if `in_sub` is 1; `add_sub` is not used.
  - `exc` is cleared to 0, `count` is set to 1, and `rm_q` samples `round_mode`.
  - If `in_last` is 1, go to `DONE`; otherwise go to `ACCUM`.
- `ACCUM`, each accepted beat:
  - `acc` takes the `add_sub` output, with `in_x`=`acc`, `in_y`=`in_data`, `operation`=`in_sub`, `round_mode`=`rm_q`.
  - `exc` is ORed with the `add_sub` `exceptions`.
  - `count` increments, saturating at all-ones.
  - If `in_last` is 1, go to `DONE`.
- `ACCUM` with no accepted beat: all state holds (stall).
- `DONE`:
  - `out_valid` is 1; `out_z`, `out_exceptions` and `out_count` are stable.
  - When `out_ready` is 1, go to `IDLE`.
- `in_ready` is 1 exactly when the state is not `DONE`.
- NaN, Inf and subnormal handling is entirely `add_sub` behaviour; the accumulator does not special-case operands.
- `round_mode` changes in the middle of a vector are ignored.

## Timing
- Reset values: state `IDLE`; `acc`, `exc` and `count` all 0. Outputs at reset: `out_valid`=0, `in_ready`=1, `out_z`=`32'h0`, `out_exceptions`=0, `out_count`=0.
- Throughput: one element per cycle with no bubbles while in `IDLE`/`ACCUM`.
- Latency: `out_valid` rises on the edge that accepts the `in_last` beat, so the result is visible in the following cycle.
- In `DONE`, an `out_ready` handshake and a pending `in_valid` in the same cycle: only the output handshake completes, because `in_ready` is 0. The new vector's first beat is accepted no earlier than the next cycle. This gives one bubble between vectors.
- `out_*` outputs hold their values after the handshake until the next vector completes; only `out_valid` drops.
- `rst` asserted mid-vector: everything clears immediately and asynchronously; the partial sum is discarded with no output.
- `in_data`, `in_sub` and `in_last` are don't-care when `in_valid` is 0.
- The combinational path runs from the `acc` register through `add_sub` back to `acc`; there is no pipelining inside this block.

## Structure
- Shared package `fp_pkg` holds:
  - `FP32_W` = 32 and `EXC_W` = 5;
  - round-mode constants (`RM_RNE` = `3'b000`, etc.) matching `add_sub`;
  - `FP32_POS_ZERO`, `FP32_POS_INF` and `FP32_QNAN`;
  - the `acc_state_t` enum.
- Single sub-module: one instance of the existing `add_sub`. The FSM, registers and counter stay in `fp32_accumulator`.

## Test plan
- **Simple sum:** beats `3f800000`, `3f800000`, `3f800000`(`in_last`), `in_sub`=0, RNE -> `out_z`=`40400000`, `out_count`=3, `out_exceptions`=0, `out_valid` 1 cycle after the last beat.
- **Subtract and single beat:**
  - `40000000`, then `3f800000` with `in_sub`=1 and `in_last` -> `3f800000`.
  - Single beat `3f800000` with `in_sub`=1 and `in_last` -> `bf800000`, count 1.
- **Special values:**
  - `7f800000` + `3f800000` -> `7f800000`.
  - `7fc00000` + `3f800000` -> NaN result with the invalid bit set as `add_sub` reports.
- **Overflow:** `7f7fffff` + `7f7fffff` (`in_last`) -> `7f800000` with the overflow bit set; a following vector `3f800000`(`in_last`) -> exceptions 0 (sticky bits cleared per vector).
- **Backpressure:**
  - With `out_ready`=0 for 5 cycles: `out_valid` holds, outputs are stable, and `in_ready`=0.
  - Then `out_ready` and `in_valid` rise together -> the new beat is accepted on the next cycle only.
- **Reset mid-vector:** after 2 beats, pulse `rst` between clock edges -> the outputs immediately take their reset values; a new vector `40000000`(`in_last`) -> `out_z`=`40000000`, count 1.
